// File: rtl/univ_reg.sv
// univ_reg: universal register with parallel load, shift, rotate and up/down count.
//
// Parameters
//   WIDTH      register width in bits (2..64)
//   RESET_VAL  value loaded into q on reset and on synchronous clear
//
// Ports
//   clk     clock; all state updates on its rising edge
//   rst_n   asynchronous active-low reset, forces q to RESET_VAL
//   clr     synchronous clear to RESET_VAL (wins over en)
//   en      operation enable; when low q holds
//   mode    operation select:
//             000 hold, 001 load d, 010 shift left, 011 shift right,
//             100 rotate left, 101 rotate right, 110 count up, 111 count down
//   d       parallel load data
//   sin_r   serial input into the LSB on shift left
//   sin_l   serial input into the MSB on shift right
//   q       registered state
//   q_bar   bitwise complement of q
//   sout    bit shifted/rotated out by the current mode, 0 for other modes
//   tc      terminal count: enabled count about to wrap
//   zero    q equals 0
module univ_reg #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout,
    output logic             tc,
    output logic             zero
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("univ_reg: WIDTH must be in 2..64");
    end

    // All eight encodings are named, so the decode has no undefined value.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             all_ones;
    logic             all_zero;

    assign mode_sel = mode_e'(mode);
    assign all_ones = &q_r;
    assign all_zero = ~|q_r;

    // Next-state value for an enabled operation; only sampled on the clock
    // edge, so d and the serial inputs never reach q combinationally.
    always_comb begin
        q_next = q_r;
        unique case (mode_sel)
            MODE_HOLD: q_next = q_r;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q_r[WIDTH-2:0], sin_r};
            MODE_SHR:  q_next = {sin_l, q_r[WIDTH-1:1]};
            MODE_ROL:  q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            MODE_ROR:  q_next = {q_r[0], q_r[WIDTH-1:1]};
            MODE_INC:  q_next = q_r + ONE;
            MODE_DEC:  q_next = q_r - ONE;
            default:   q_next = q_r;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else if (clr) begin
            q_r <= RESET_VAL;
        end else if (en) begin
            q_r <= q_next;
        end
    end

    always_comb begin
        sout = 1'b0;
        unique case (mode_sel)
            MODE_SHL, MODE_ROL: sout = q_r[WIDTH-1];
            MODE_SHR, MODE_ROR: sout = q_r[0];
            default:            sout = 1'b0;
        endcase
    end

    // Terminal count is qualified by en/clr so it flags only a wrap that
    // will actually happen on the coming edge.
    always_comb begin
        tc = 1'b0;
        if (en && !clr) begin
            if (mode_sel == MODE_INC) begin
                tc = all_ones;
            end else if (mode_sel == MODE_DEC) begin
                tc = all_zero;
            end
        end
    end

    assign q     = q_r;
    assign q_bar = ~q_r;
    assign zero  = all_zero;

endmodule

// File: tb/tb_univ_reg.sv
module tb_univ_reg;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       sout;
    logic       tc;
    logic       zero;

    int unsigned n_checks;
    int unsigned n_fail;

    univ_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .q     (q),
        .q_bar (q_bar),
        .sout  (sout),
        .tc    (tc),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        en   = 1'b1;
        clr  = 1'b0;
        mode = 3'b001;
        d    = val;
        tick();
    endtask

    logic [7:0] rol_sout_exp;
    logic [7:0] ror_sout_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rol_sout_exp = 8'b1000_0001;
        ror_sout_exp = 8'b1000_0001;
        clr = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_q", q, 8'h00);
        check("reset_qbar", q_bar, 8'hFF);
        check("reset_zero", zero, 1'b1);

        #10 rst_n = 1'b1;    // released between edges
        load(8'hA5);
        check("load_q", q, 8'hA5);
        check("load_qbar", q_bar, 8'h5A);
        check("load_zero", zero, 1'b0);

        mode = 3'b010; sin_r = 1'b1; #1;
        check("shl_sout", sout, 1'b1);
        tick();
        check("shl_q", q, 8'h4B);
        mode = 3'b011; sin_l = 1'b0; #1;
        check("shr_sout", sout, 1'b1);
        tick();
        check("shr_q", q, 8'h25);
        sin_l = 1'b1;
        tick();
        check("shr_sin1_q", q, 8'h92);

        mode = 3'b000;
        tick();
        check("hold_en_q", q, 8'h92);
        check("hold_sout", sout, 1'b0);

        load(8'h81);
        mode = 3'b100;
        for (int i = 7; i >= 0; i--) begin
            #1;
            check("rol_sout", sout, rol_sout_exp[i]);
            tick();
        end
        check("rol8_q", q, 8'h81);

        mode = 3'b101;
        for (int i = 7; i >= 0; i--) begin
            #1;
            check("ror_sout", sout, ror_sout_exp[i]);
            tick();
        end
        check("ror8_q", q, 8'h81);

        load(8'hFE);
        mode = 3'b110; #1;
        check("inc_tc_fe", tc, 1'b0);
        tick();
        check("inc_q_ff", q, 8'hFF);
        check("inc_tc_ff", tc, 1'b1);
        check("inc_sout", sout, 1'b0);
        tick();
        check("inc_wrap_q", q, 8'h00);
        check("inc_wrap_zero", zero, 1'b1);
        mode = 3'b111; #1;
        check("dec_tc_00", tc, 1'b1);
        tick();
        check("dec_wrap_q", q, 8'hFF);
        check("dec_tc_ff", tc, 1'b0);
        tick();
        check("dec_q", q, 8'hFE);

        load(8'h3C);
        en = 1'b0; clr = 1'b1;
        tick();
        check("clr_en0_q", q, 8'h00);
        clr = 1'b0; mode = 3'b110;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("en0_tc", tc, 1'b0);
            tick();
        end
        check("en0_q", q, 8'h00);

        load(8'h3C);
        en = 1'b0; mode = 3'b110;
        repeat (5) tick();
        check("en0_hold_q", q, 8'h3C);

        en = 1'b1; mode = 3'b001; d = 8'hAA; clr = 1'b1; #1;
        check("clr_tc", tc, 1'b0);
        tick();
        check("clr_prio_q", q, 8'h00);
        clr = 1'b0;

        load(8'h10);
        mode = 3'b110;
        tick();
        check("cnt_q_11", q, 8'h11);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_q", q, 8'h00);
        check("midrst_qbar", q_bar, 8'hFF);
        repeat (2) tick();
        check("rst_hold_q", q, 8'h00);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_q", q, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
